// File: rtl/alarm_sched.sv
// ---------------------------------------------------------------------------
// alarm_sched
//   Four-slot alarm scheduler. Holds four BCD HH:MM:SS alarm times and
//   compares them with the running time on every sec_tick. Matching slots
//   are queued in a pending mask. A single bell is handed to the lowest
//   pending slot. A ring ends on dismiss, on snooze or on timeout.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined     : SNOOZE state is built. The snooze button defers the
//                   ring by SNOOZE_SECS ticks.
//     not defined : a snooze pulse while ringing acts exactly like dismiss.
//
// Parameters
//   RING_SECS    sec_ticks a ring lasts before auto-dismiss (1..511)
//   SNOOZE_SECS  sec_ticks of one snooze interval (1..511)
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cnt          current time, BCD {H1,H0,M1,M0,S1,S0}
//   i_sec_tick     one-cycle pulse per second
//   i_wr_en        slot table write strobe
//   i_wr_slot      slot index to write
//   i_wr_time      BCD alarm time for the slot
//   i_wr_slot_en   enable bit written with the slot
//   i_snooze       one-cycle snooze button pulse
//   i_dismiss      one-cycle dismiss button pulse
//   o_ring         bell drive, high while ringing
//   o_led          blink pattern while ringing, 00 otherwise
//   o_active_slot  slot owning the bell (RING or SNOOZE)
//   o_pending      slots matched but not yet serviced
//
// FSM states
//   state  | meaning
//   IDLE   | bell free, services the lowest pending slot
//   RING   | bell on for o_active_slot, counting ring seconds
//   SNOOZE | bell off, counting snooze seconds before re-ringing
// ---------------------------------------------------------------------------
module alarm_sched #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_cnt,
    input  logic        i_sec_tick,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_slot,
    input  logic [23:0] i_wr_time,
    input  logic        i_wr_slot_en,
    input  logic        i_snooze,
    input  logic        i_dismiss,
    output logic        o_ring,
    output logic [1:0]  o_led,
    output logic [1:0]  o_active_slot,
    output logic [3:0]  o_pending
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [8:0] SNOOZE_LIM = 9'(SNOOZE_SECS);
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1
    } state_t;
`endif

    localparam logic [8:0] RING_LIM = 9'(RING_SECS);

    // slot table
    logic [23:0] r_time [4];
    logic [3:0]  r_en;

    // sequencer state
    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [1:0]  r_led;
    logic [1:0]  r_active;
    logic [3:0]  r_pending;

    // combinational
    state_t      w_state_nxt;
    logic [8:0]  w_cnt_nxt;
    logic [8:0]  w_cnt_inc;
    logic [1:0]  w_led_nxt;
    logic [1:0]  w_active_nxt;
    logic [3:0]  w_match;
    logic [3:0]  w_match_eff;
    logic [3:0]  w_pend_all;
    logic [3:0]  w_svc_clr;
    logic [3:0]  w_wr_clr;
    logic [3:0]  w_pending_nxt;
    logic [1:0]  w_lowest;

    // -----------------------------------------------------------------------
    // Slot table. The compare below reads the pre-write contents, so a write
    // landing on the same edge as a matching tick does not affect that tick.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_time[i] <= '0;
            end
            r_en <= '0;
        end else if (i_wr_en) begin
            r_time[i_wr_slot] <= i_wr_time;
            r_en[i_wr_slot]   <= i_wr_slot_en;
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < 4; i++) begin
            w_match[i] = i_sec_tick && r_en[i] && (r_time[i] == i_cnt);
        end
    end

    // A slot that already owns the bell must not queue itself again.
    always_comb begin
        w_match_eff = w_match;
        if (r_state != ST_IDLE) begin
            w_match_eff = w_match & ~(4'b0001 << r_active);
        end
    end

    assign w_pend_all = r_pending | w_match_eff;
    assign w_wr_clr   = (i_wr_en && !i_wr_slot_en) ? (4'b0001 << i_wr_slot) : 4'b0000;
    assign w_cnt_inc  = r_cnt + 9'd1;

    always_comb begin
        w_lowest = 2'd0;
        if (w_pend_all[0]) begin
            w_lowest = 2'd0;
        end else if (w_pend_all[1]) begin
            w_lowest = 2'd1;
        end else if (w_pend_all[2]) begin
            w_lowest = 2'd2;
        end else begin
            w_lowest = 2'd3;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_led     <= 2'b00;
            r_active  <= 2'd0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_led     <= w_led_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_led_nxt    = r_led;
        w_active_nxt = r_active;
        w_svc_clr    = '0;

        case (r_state)
            ST_IDLE: begin
                w_led_nxt = 2'b00;
                if (|w_pend_all) begin
                    w_state_nxt  = ST_RING;
                    w_active_nxt = w_lowest;
                    w_svc_clr    = 4'b0001 << w_lowest;
                    w_cnt_nxt    = '0;
                    w_led_nxt    = 2'b01;
                end
            end

            ST_RING: begin
                // dismiss has priority over snooze
                if (i_dismiss) begin
                    w_state_nxt = ST_IDLE;
                    w_led_nxt   = 2'b00;
                end else if (i_snooze) begin
`ifdef ALARM_SNOOZE_EN
                    w_state_nxt = ST_SNOOZE;
                    w_cnt_nxt   = '0;
`else
                    w_state_nxt = ST_IDLE;
`endif
                    w_led_nxt   = 2'b00;
                end else if (i_sec_tick) begin
                    if (w_cnt_inc == RING_LIM) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_led_nxt   = 2'b00;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        w_led_nxt = ~r_led;
                    end
                end
            end

`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                w_led_nxt = 2'b00;
                if (i_dismiss) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_sec_tick) begin
                    if (w_cnt_inc == SNOOZE_LIM) begin
                        w_state_nxt = ST_RING;
                        w_cnt_nxt   = '0;
                        w_led_nxt   = 2'b01;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_led_nxt   = 2'b00;
            end
        endcase
    end

    // Disabling a slot also withdraws any queued request from it.
    assign w_pending_nxt = w_pend_all & ~w_svc_clr & ~w_wr_clr;

    assign o_ring        = (r_state == ST_RING);
    assign o_led         = r_led;
    assign o_active_slot = r_active;
    assign o_pending     = r_pending;

endmodule

// File: tb/tb_alarm_sched.sv
module tb_alarm_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] cnt = '0;
    logic        sec_tick = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_slot = '0;
    logic [23:0] wr_time = '0;
    logic        wr_slot_en = 1'b0;
    logic        snooze = 1'b0;
    logic        dismiss = 1'b0;
    logic        ring;
    logic [1:0]  led;
    logic [1:0]  active_slot;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    alarm_sched #(.RING_SECS(60), .SNOOZE_SECS(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cnt         (cnt),
        .i_sec_tick    (sec_tick),
        .i_wr_en       (wr_en),
        .i_wr_slot     (wr_slot),
        .i_wr_time     (wr_time),
        .i_wr_slot_en  (wr_slot_en),
        .i_snooze      (snooze),
        .i_dismiss     (dismiss),
        .o_ring        (ring),
        .o_led         (led),
        .o_active_slot (active_slot),
        .o_pending     (pending)
    );

    always #5 clk = ~clk;

    // inputs set before the call are captured at the edge; outputs are
    // stable 1 time unit later when the caller checks them
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input logic [1:0] s, input logic [23:0] t, input logic en);
        wr_en = 1'b1; wr_slot = s; wr_time = t; wr_slot_en = en;
        step();
        wr_en = 1'b0;
    endtask

    task automatic sec(input logic [23:0] t);
        cnt = t; sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic press_dismiss();
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_ring got=%b exp=0", ring); end
        total++; if (led !== 2'b00) begin bad++; $display("FAIL reset_led got=%b exp=00", led); end
        total++; if (active_slot !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", active_slot); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        // cleared table entries are disabled, so time 00:00:00 must not match
        sec(24'h000000);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_table_ring got=%b exp=0", ring); end
    endtask

    task automatic test_match();
        write_slot(2'd2, 24'h070000, 1'b1);
        sec(24'h065959);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL match_early got=%b exp=0", ring); end
        sec(24'h070000);
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL match_ring got=%b exp=1", ring); end
        total++; if (active_slot !== 2'd2) begin bad++; $display("FAIL match_active got=%0d exp=2", active_slot); end
        total++; if (led !== 2'b01) begin bad++; $display("FAIL match_led0 got=%b exp=01", led); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL match_pending got=%b exp=0000", pending); end
        sec(24'h070001);
        total++; if (led !== 2'b10) begin bad++; $display("FAIL match_led1 got=%b exp=10", led); end
        sec(24'h070002);
        total++; if (led !== 2'b01) begin bad++; $display("FAIL match_led2 got=%b exp=01", led); end
        press_dismiss();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL match_dismiss got=%b exp=0", ring); end
        total++; if (led !== 2'b00) begin bad++; $display("FAIL match_dismiss_led got=%b exp=00", led); end
    endtask

    task automatic test_timeout();
        write_slot(2'd0, 24'h080000, 1'b1);
        sec(24'h080000);
        total++; if (ring !== 1'b1 || active_slot !== 2'd0) begin
            bad++; $display("FAIL timeout_start ring=%b slot=%0d exp ring=1 slot=0", ring, active_slot);
        end
        for (int i = 0; i < 59; i++) begin
            sec(24'h080001);
        end
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL timeout_59 got=%b exp=1", ring); end
        total++; if (led !== 2'b10) begin bad++; $display("FAIL timeout_59_led got=%b exp=10", led); end
        sec(24'h080001);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL timeout_60 got=%b exp=0", ring); end
        total++; if (led !== 2'b00) begin bad++; $display("FAIL timeout_60_led got=%b exp=00", led); end
        step();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b exp=0", ring); end
    endtask

    task automatic test_priority();
        write_slot(2'd1, 24'h120000, 1'b1);
        write_slot(2'd3, 24'h120000, 1'b1);
        sec(24'h120000);
        total++; if (ring !== 1'b1 || active_slot !== 2'd1) begin
            bad++; $display("FAIL prio_first ring=%b slot=%0d exp ring=1 slot=1", ring, active_slot);
        end
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL prio_pending got=%b exp=1000", pending); end
        press_dismiss();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL prio_idle_gap got=%b exp=0", ring); end
        step();
        total++; if (ring !== 1'b1 || active_slot !== 2'd3) begin
            bad++; $display("FAIL prio_second ring=%b slot=%0d exp ring=1 slot=3", ring, active_slot);
        end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL prio_pending2 got=%b exp=0000", pending); end
        // slot 3 is ringing: its own rematch is dropped, slot 1 queues
        sec(24'h120000);
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL prio_drop got=%b exp=0010", pending); end
        press_dismiss();
        step();
        total++; if (ring !== 1'b1 || active_slot !== 2'd1) begin
            bad++; $display("FAIL prio_third ring=%b slot=%0d exp ring=1 slot=1", ring, active_slot);
        end
        press_dismiss();
        step();
        total++; if (ring !== 1'b0 || pending !== 4'b0000) begin
            bad++; $display("FAIL prio_done ring=%b pend=%b exp ring=0 pend=0000", ring, pending);
        end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        sec(24'h080000);
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL snz_start got=%b exp=1", ring); end
        snooze = 1'b1; step(); snooze = 1'b0;
        total++; if (ring !== 1'b0 || active_slot !== 2'd0) begin
            bad++; $display("FAIL snz_enter ring=%b slot=%0d exp ring=0 slot=0", ring, active_slot);
        end
        for (int i = 0; i < 4; i++) begin
            sec(24'h080001);
        end
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_4 got=%b exp=0", ring); end
        sec(24'h080001);
        total++; if (ring !== 1'b1 || active_slot !== 2'd0 || led !== 2'b01) begin
            bad++; $display("FAIL snz_5 ring=%b slot=%0d led=%b exp ring=1 slot=0 led=01", ring, active_slot, led);
        end
        snooze = 1'b1; dismiss = 1'b1; step(); snooze = 1'b0; dismiss = 1'b0;
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_both got=%b exp=0", ring); end
        for (int i = 0; i < 6; i++) begin
            sec(24'h080001);
        end
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_both_idle got=%b exp=0", ring); end
    endtask
`else
    task automatic test_snooze();
        sec(24'h120000);
        total++; if (ring !== 1'b1 || active_slot !== 2'd1 || pending !== 4'b1000) begin
            bad++; $display("FAIL snz_start ring=%b slot=%0d pend=%b exp 1/1/1000", ring, active_slot, pending);
        end
        snooze = 1'b1; step(); snooze = 1'b0;
        total++; if (ring !== 1'b0 || pending !== 4'b1000) begin
            bad++; $display("FAIL snz_as_dismiss ring=%b pend=%b exp ring=0 pend=1000", ring, pending);
        end
        step();
        total++; if (ring !== 1'b1 || active_slot !== 2'd3) begin
            bad++; $display("FAIL snz_next ring=%b slot=%0d exp ring=1 slot=3", ring, active_slot);
        end
        press_dismiss();
        step();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_done got=%b exp=0", ring); end
    endtask
`endif

    task automatic test_disable_and_reset();
        sec(24'h120000);
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL dis_pending got=%b exp=1000", pending); end
        write_slot(2'd3, 24'h120000, 1'b0);
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL dis_clear got=%b exp=0000", pending); end
        press_dismiss();
        step();
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL dis_no_ring got=%b exp=0", ring); end
        sec(24'h080000);
        sec(24'h120000);
        total++; if (ring !== 1'b1 || pending !== 4'b0010) begin
            bad++; $display("FAIL rst_setup ring=%b pend=%b exp ring=1 pend=0010", ring, pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ring !== 1'b0 || led !== 2'b00 || pending !== 4'b0000 || active_slot !== 2'd0) begin
            bad++; $display("FAIL rst_async ring=%b led=%b pend=%b slot=%0d exp 0/00/0000/0", ring, led, pending, active_slot);
        end
        #10;
        rst_n = 1'b1;
        sec(24'h080000);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL rst_table_lost got=%b exp=0", ring); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_timeout();
        test_priority();
        test_snooze();
        test_disable_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_sched.md
# alarm_sched

Four-slot alarm scheduler for the board clock. Holds four BCD HH:MM:SS alarm times, compares them against the running time once per second, and arbitrates the single bell/LED output between slots with priority, pending-queue, timeout and snooze handling. Sits between the time-keeping counter (24-bit BCD time plus 1 Hz tick) and the LED/bell drive, replacing per-alarm window comparison with one sequenced resource.

## Interface
- RING_SECS, 60, sec_tick count a ring lasts before auto-dismiss (1..511)
- SNOOZE_SECS, 300, sec_tick count of a snooze interval (1..511)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cnt  in  24  current time, BCD HH:MM:SS ({H1,H0,M1,M0,S1,S0} nibbles)
- sec_tick  in  1  one-cycle pulse each time cnt advances by one second
- wr_en  in  1  write strobe for slot table
- wr_slot  in  2  slot index to write
- wr_time  in  24  BCD alarm time for the slot
- wr_slot_en  in  1  enable bit written with the slot
- snooze  in  1  debounced one-cycle button pulse
- dismiss  in  1  debounced one-cycle button pulse
- ring  out  1  bell drive, high while in RING
- led  out  2  blink pattern while ringing
- active_slot  out  2  slot currently owning the bell (RING or SNOOZE)
- pending  out  4  slots matched but not yet serviced

## Operation
- Slot table: 4 × (24-bit time, enable bit); all cleared at reset. wr_en writes time and enable of wr_slot on the clock edge. Writing enable=0 also clears that slot's pending bit.
- Match: on a cycle with sec_tick=1, slot i matches when enabled and time == cnt (exact 24-bit compare, using table contents before any same-cycle write). Matches OR into pending.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE: if pending≠0 (including matches this cycle), next state RING, active_slot = lowest set index, clear that pending bit, clear sec counter.
  - RING: sec counter increments on sec_tick; dismiss → IDLE; snooze → SNOOZE (counter cleared); counter reaching RING_SECS on a tick → IDLE (auto-dismiss).
  - SNOOZE: counter increments on sec_tick; dismiss → IDLE; counter reaching SNOOZE_SECS → RING with same active_slot, counter cleared; snooze ignored.
- Matches during RING/SNOOZE only set pending; serviced from IDLE, lowest index first. A match on active_slot during RING/SNOOZE is dropped (not queued).
- dismiss and snooze in same cycle: dismiss wins.
- led: 2'b01 on entering RING, inverted (01↔10) on each sec_tick in RING; 2'b00 outside RING.
- Counter 9 bits; compare is equality with the parameter value.

## Timing
- Reset values: ring=0, led=2'b00, active_slot=0, pending=0, state IDLE, counter 0, table cleared.
- Match-to-ring latency: ring high the cycle after the sec_tick edge that matched (one clock).
- Button response: state change visible one clock after the pulse.
- Ring lasts exactly RING_SECS sec_ticks counted from the first tick after entry.
- IDLE→RING for next pending slot occurs the cycle after returning to IDLE (one idle cycle minimum between rings).
- rst_n low mid-ring: outputs drop asynchronously to reset values; table contents lost.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state and snooze input behave as above.
- Not defined: SNOOZE state not built; snooze pulse in RING behaves exactly as dismiss; SNOOZE_SECS unused.

## Test plan
- Write slot 2 = 24'h070000 enabled; drive cnt=24'h070000 with sec_tick → ring=1 next cycle, active_slot=2, led=01 then 10 on next tick.
- Slot 0 ringing, no buttons, RING_SECS=60 → ring falls after 60th sec_tick, state IDLE, led=00.
- Slots 1 and 3 both = 24'h120000, match together → slot 1 rings, pending=4'b1000; dismiss → slot 3 rings one idle cycle later.
- With ALARM_SNOOZE_EN, SNOOZE_SECS=5: snooze during ring → ring=0 for 5 ticks, then ring=1 same slot; snooze+dismiss same cycle in RING → IDLE.
- Without ALARM_SNOOZE_EN: snooze pulse in RING → IDLE, pending unchanged.
- Pending slot 1 then write slot 1 enable=0 → pending bit clears; rst_n low mid-ring → ring=0, led=00, pending=0 immediately.
